// File: rtl/cacheline_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cacheline_arbiter
// Description : Shares one physical-memory cacheline port between the
//               I-cache and D-cache. One whole-line transaction at a time,
//               round-robin on ties, request fields latched at grant.
// Revision    : 1.0 - initial release
// ============================================================================
module cacheline_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  // I-cache port
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  // D-cache port
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  // physical memory port
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_last_grant;   // 0 = I, 1 = D
  logic                    r_op_write;
  logic [ADDR_WIDTH-1:0]   r_addr_q;
  logic [LINE_WIDTH-1:0]   r_wdata_q;

  logic                    w_pending_i;
  logic                    w_pending_d;
  logic                    w_grant_i;
  logic                    w_grant_d;
  logic                    w_busy;

  assign w_pending_i = i_read;
  assign w_pending_d = d_read | d_write;

  // Next-state and grant decision; grants are only made from IDLE.
  always_comb begin
    w_state_next = r_state;
    w_grant_i    = 1'b0;
    w_grant_d    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pending_i && w_pending_d) begin
          // tie: serve the port that did not win last time
          if (r_last_grant) w_grant_i = 1'b1;
          else              w_grant_d = 1'b1;
        end else if (w_pending_i) begin
          w_grant_i = 1'b1;
        end else if (w_pending_d) begin
          w_grant_d = 1'b1;
        end
        if (w_grant_i) w_state_next = SERVE_I;
        if (w_grant_d) w_state_next = SERVE_D;
      end
      SERVE_I: if (pmem_resp) w_state_next = IDLE;
      SERVE_D: if (pmem_resp) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // State register plus the transaction fields captured at grant time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_last_grant <= 1'b1;
      r_op_write   <= 1'b0;
      r_addr_q     <= '0;
      r_wdata_q    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_grant_i) begin
        r_addr_q     <= i_address;
        r_op_write   <= 1'b0;
        r_last_grant <= 1'b0;
      end
      if (w_grant_d) begin
        r_addr_q     <= d_address;
        // a simultaneous read+write request is treated as a write-back
        r_op_write   <= d_write;
        r_wdata_q    <= d_wdata;
        r_last_grant <= 1'b1;
      end
    end
  end

  // Memory side is driven purely from registers, so requester inputs
  // never reach the pmem outputs combinationally.
  assign w_busy       = (r_state != IDLE);
  assign pmem_read    = w_busy & ~r_op_write;
  assign pmem_write   = w_busy &  r_op_write;
  assign pmem_address = r_addr_q;
  assign pmem_wdata   = r_wdata_q;

  // Responses relay the memory pulse only to the port being served.
  assign i_resp  = (r_state == SERVE_I) & pmem_resp;
  assign d_resp  = (r_state == SERVE_D) & pmem_resp;
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_cacheline_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_cacheline_arbiter
// Description : Scoreboard bench for cacheline_arbiter with a fixed-latency
//               memory model and directed requester traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cacheline_arbiter;

  localparam int LW      = 256;
  localparam int AW      = 32;
  localparam int MEM_LAT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata;
  logic          pmem_resp;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } txn_t;

  txn_t          exp_pmem[$];
  logic [LW-1:0] exp_i[$];
  logic [LW-1:0] exp_d[$];

  int n_checks = 0;
  int n_fail   = 0;
  int spur_req = 0;

  cacheline_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  // Memory contents: one hand-picked line, the rest derived from the address.
  function automatic logic [LW-1:0] rdata_for(input logic [AW-1:0] a);
    if (a == 32'h0000_1040) return {32{8'hA5}};
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: answers MEM_LAT cycles into a held strobe; can also
  // inject one stray response while idle.
  initial begin : mem_model
    int cnt;
    int spur_done;
    cnt = 0;
    spur_done = 0;
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      pmem_resp = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (spur_req != spur_done && !pmem_read && !pmem_write) begin
        spur_done++;
        pmem_resp = 1'b1;
        pmem_rdata = '1;
      end else if (pmem_read || pmem_write) begin
        cnt++;
        if (cnt == MEM_LAT) begin
          pmem_resp = 1'b1;
          pmem_rdata = rdata_for(pmem_address);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT completes something.
  initial begin : monitor
    txn_t t;
    int   cyc;
    int   last_resp_cyc;
    bit   have_resp;
    bit   prev_strobe;
    logic [LW-1:0] e;
    cyc = 0;
    last_resp_cyc = 0;
    have_resp = 0;
    prev_strobe = 0;
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (pmem_read && pmem_write) check("both_strobes", 1'b1, 1'b0);
      if ((pmem_read || pmem_write) && !prev_strobe && have_resp)
        check("grant_gap_ge2", (cyc - last_resp_cyc) >= 2, 1'b1);
      prev_strobe = pmem_read | pmem_write;
      if (pmem_resp && (pmem_read || pmem_write)) begin
        last_resp_cyc = cyc;
        have_resp = 1;
        if (exp_pmem.size() == 0) begin
          check("pmem_unexpected", 1'b1, 1'b0);
        end else begin
          t = exp_pmem.pop_front();
          check("pmem_op", {pmem_read, pmem_write}, {~t.wr, t.wr});
          check("pmem_addr", pmem_address, t.addr);
          if (t.wr) check("pmem_wdata", pmem_wdata, t.wdata);
        end
      end
      if (i_resp) begin
        if (exp_i.size() == 0) check("i_resp_unexpected", 1'b1, 1'b0);
        else begin e = exp_i.pop_front(); check("i_rdata", i_rdata, e); end
      end
      if (d_resp) begin
        if (exp_d.size() == 0) check("d_resp_unexpected", 1'b1, 1'b0);
        else begin e = exp_d.pop_front(); check("d_rdata", d_rdata, e); end
      end
    end
  end

  function automatic txn_t mk(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] w);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = w;
    return t;
  endfunction

  task automatic req_i(input logic [AW-1:0] a);
    bit seen;
    seen = 0;
    i_address = a;
    i_read = 1'b1;
    exp_i.push_back(rdata_for(a));
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk); #1;
      if (i_resp) seen = 1;
    end
    check("i_resp_seen", seen, 1'b1);
    @(posedge clk); #1;
    i_read = 1'b0;
  endtask

  task automatic req_d(input logic [AW-1:0] a, input logic rd, input logic wr, input logic [LW-1:0] w);
    bit seen;
    seen = 0;
    d_address = a;
    d_wdata = w;
    d_read = rd;
    d_write = wr;
    exp_d.push_back(rdata_for(a));
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk); #1;
      if (d_resp) seen = 1;
    end
    check("d_resp_seen", seen, 1'b1);
    @(posedge clk); #1;
    d_read = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Directed stimulus.
  initial begin : stim
    rst = 1'b1;
    i_read = 0; i_address = '0;
    d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk); #1;
    check("rst_pmem_read", pmem_read, 1'b0);
    check("rst_pmem_write", pmem_write, 1'b0);
    check("rst_resps", {i_resp, d_resp}, 2'b00);
    check("rst_pmem_addr", pmem_address, 32'h0);

    // reset in the middle of a D write-back
    @(posedge clk); #1;
    d_write = 1'b1; d_address = 32'h0000_0040; d_wdata = {8{32'hDEAD_BEEF}};
    @(posedge clk); #1;
    check("mid_serve_write", pmem_write, 1'b1);
    rst = 1'b1; d_write = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_strobes", {pmem_read, pmem_write}, 2'b00);
    check("mid_rst_addr", pmem_address, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      check("post_rst_idle", {pmem_read, pmem_write, i_resp, d_resp}, 4'b0000);
    end

    // lone I read with cycle-exact strobe and response timing
    @(posedge clk); #1;
    exp_pmem.push_back(mk(1'b0, 32'h0000_1040, '0));
    exp_i.push_back({32{8'hA5}});
    i_read = 1'b1; i_address = 32'h0000_1040;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      @(negedge clk); #1;
      check("lone_i_read", pmem_read, 1'b1);
      check("lone_i_addr", pmem_address, 32'h0000_1040);
      check("lone_i_resp", {i_resp, d_resp}, {(k == 4), 1'b0});
      if (k == 4) check("lone_i_rdata", i_rdata, {32{8'hA5}});
    end
    @(posedge clk); #1;
    i_read = 1'b0;
    @(negedge clk); #1;
    check("lone_i_done", {pmem_read, pmem_write}, 2'b00);

    // D write-back; requester fields change mid-transaction
    exp_pmem.push_back(mk(1'b1, 32'h8000_0020, {8{32'h1234_5678}}));
    fork
      req_d(32'h8000_0020, 1'b0, 1'b1, {8{32'h1234_5678}});
      begin
        repeat (2) @(posedge clk);
        #2 d_address = 32'hFFFF_FFE0; d_wdata = '0;
        @(negedge clk); #1;
        check("dwb_addr_held", pmem_address, 32'h8000_0020);
      end
    join

    // simultaneous requests straight after reset: I first, then D
    reset_dut();
    exp_pmem.push_back(mk(1'b0, 32'h0000_2000, '0));
    exp_pmem.push_back(mk(1'b0, 32'h0000_3000, '0));
    fork
      req_i(32'h0000_2000);
      req_d(32'h0000_3000, 1'b1, 1'b0, '0);
    join

    // both ports kept busy: grants alternate I, D, I, D
    exp_pmem.push_back(mk(1'b0, 32'h0000_2100, '0));
    exp_pmem.push_back(mk(1'b0, 32'h0000_3100, '0));
    exp_pmem.push_back(mk(1'b0, 32'h0000_2140, '0));
    exp_pmem.push_back(mk(1'b1, 32'h0000_3140, {8{32'hCAFE_F00D}}));
    fork
      begin req_i(32'h0000_2100); req_i(32'h0000_2140); end
      begin
        req_d(32'h0000_3100, 1'b1, 1'b0, '0);
        req_d(32'h0000_3140, 1'b0, 1'b1, {8{32'hCAFE_F00D}});
      end
    join

    // illegal read+write from D is carried out as a write
    exp_pmem.push_back(mk(1'b1, 32'h0000_4000, {8{32'h0BAD_F00D}}));
    req_d(32'h0000_4000, 1'b1, 1'b1, {8{32'h0BAD_F00D}});

    // stray memory response while idle must not reach either cache
    @(posedge clk); #1;
    spur_req++;
    @(negedge clk); #1;
    check("spur_applied", pmem_resp, 1'b1);
    check("spur_no_resp", {i_resp, d_resp}, 2'b00);
    check("spur_no_strobe", {pmem_read, pmem_write}, 2'b00);
    @(negedge clk); #1;
    check("spur_still_idle", {pmem_read, pmem_write}, 2'b00);

    repeat (4) @(posedge clk);
    check("exp_pmem_drained", exp_pmem.size(), 0);
    check("exp_i_drained", exp_i.size(), 0);
    check("exp_d_drained", exp_d.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute guard against a stuck run.
  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
